block_ctrl_unit: RTL and testbench



---
 rtl/block_ctrl_unit.sv | 316 +++++++++++++++++++++++++++++++
 tb/tb_block_ctrl_unit.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/block_ctrl_unit.sv
// ----------------------------------------------------------------------------
// block_ctrl_unit
// Decode/control unit for the ID stage of the pipelined ARM-subset core.
// It decodes data-processing, single load/store and branch instructions into
// ALU, memory and write-back controls, with one cycle of latency. It also
// splits LDM/STM block transfers into one micro-op per listed register, and
// holds upstream (busy) until the final micro-op has been issued.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   valid_in        an instruction is present at decode
//   mode[1:0]       00 data-proc, 01 load/store, 10 branch, 11 reserved
//   opcode[3:0]     data-processing opcode
//   sIn             S bit (mode 00) / L bit (mode 01)
//   blk             the mode-01 instruction is a block transfer
//   reg_list        block-transfer register list, bit i = Ri
//   freeze          hold all state and outputs
//   flush           kill the output and abort any block sequence
//   aluCmd          ALU command
//   memRead, memWrite, wbEn, branch, sOut   control strobes
//   uop_valid       the outputs carry a live operation
//   uop_reg         register of the current block micro-op
//   uop_index       ordinal of the current block micro-op (EX adds 4*k)
//   last            final micro-op of a block transfer
//   busy            upstream must hold its current instruction
// ----------------------------------------------------------------------------
module block_ctrl_unit #(
    parameter int unsigned NUM_REGS  = 16,
    parameter int unsigned IDX_W     = $clog2(NUM_REGS),
    parameter int unsigned ALU_CMD_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_in,
    input  logic [1:0]           mode,
    input  logic [3:0]           opcode,
    input  logic                 sIn,
    input  logic                 blk,
    input  logic [NUM_REGS-1:0]  reg_list,
    input  logic                 freeze,
    input  logic                 flush,
    output logic [ALU_CMD_W-1:0] aluCmd,
    output logic                 memRead,
    output logic                 memWrite,
    output logic                 wbEn,
    output logic                 branch,
    output logic                 sOut,
    output logic                 uop_valid,
    output logic [IDX_W-1:0]     uop_reg,
    output logic [IDX_W-1:0]     uop_index,
    output logic                 last,
    output logic                 busy
);

    // Instruction classes
    localparam logic [1:0] MODE_DP  = 2'b00;
    localparam logic [1:0] MODE_LS  = 2'b01;
    localparam logic [1:0] MODE_BR  = 2'b10;

    // Data-processing opcodes
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_MVN = 4'b1111;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_TST = 4'b1000;

    // ALU commands
    localparam logic [ALU_CMD_W-1:0] ALU_MOV = ALU_CMD_W'(4'b0001);
    localparam logic [ALU_CMD_W-1:0] ALU_MVN = ALU_CMD_W'(4'b1001);
    localparam logic [ALU_CMD_W-1:0] ALU_ADD = ALU_CMD_W'(4'b0010);
    localparam logic [ALU_CMD_W-1:0] ALU_ADC = ALU_CMD_W'(4'b0011);
    localparam logic [ALU_CMD_W-1:0] ALU_SUB = ALU_CMD_W'(4'b0100);
    localparam logic [ALU_CMD_W-1:0] ALU_SBC = ALU_CMD_W'(4'b0101);
    localparam logic [ALU_CMD_W-1:0] ALU_AND = ALU_CMD_W'(4'b0110);
    localparam logic [ALU_CMD_W-1:0] ALU_ORR = ALU_CMD_W'(4'b0111);
    localparam logic [ALU_CMD_W-1:0] ALU_EOR = ALU_CMD_W'(4'b1000);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BLOCK = 1'b1
    } state_t;

    // Opcode to ALU command; compares reuse SUB, tests reuse AND
    function automatic logic [ALU_CMD_W-1:0] f_alu(input logic [3:0] op);
        logic [ALU_CMD_W-1:0] cmd;
        case (op)
            OP_MOV:  cmd = ALU_MOV;
            OP_MVN:  cmd = ALU_MVN;
            OP_ADD:  cmd = ALU_ADD;
            OP_ADC:  cmd = ALU_ADC;
            OP_SUB:  cmd = ALU_SUB;
            OP_SBC:  cmd = ALU_SBC;
            OP_AND:  cmd = ALU_AND;
            OP_ORR:  cmd = ALU_ORR;
            OP_EOR:  cmd = ALU_EOR;
            OP_CMP:  cmd = ALU_SUB;
            OP_TST:  cmd = ALU_AND;
            default: cmd = ALU_MOV;
        endcase
        return cmd;
    endfunction

    // Index of the lowest set bit (0 when the vector is empty)
    function automatic logic [IDX_W-1:0] f_lowest(input logic [NUM_REGS-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = int'(NUM_REGS) - 1; i >= 0; i--) begin
            if (v[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    // State and latched block context
    state_t                r_state;
    logic [NUM_REGS-1:0]   r_list;
    logic                  r_ld;

    // Output registers
    logic [ALU_CMD_W-1:0]  r_alu;
    logic                  r_mem_rd;
    logic                  r_mem_wr;
    logic                  r_wb;
    logic                  r_br;
    logic                  r_s;
    logic                  r_uv;
    logic [IDX_W-1:0]      r_reg;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_last;
    logic                  r_busy;

    // Next-state values
    state_t                w_state_nxt;
    logic [NUM_REGS-1:0]   w_list_nxt;
    logic                  w_ld_nxt;
    logic [ALU_CMD_W-1:0]  w_alu_nxt;
    logic                  w_mem_rd_nxt;
    logic                  w_mem_wr_nxt;
    logic                  w_wb_nxt;
    logic                  w_br_nxt;
    logic                  w_s_nxt;
    logic                  w_uv_nxt;
    logic [IDX_W-1:0]      w_reg_nxt;
    logic [IDX_W-1:0]      w_idx_nxt;
    logic                  w_last_nxt;
    logic                  w_busy_nxt;

    // Register list being walked: fresh from decode in IDLE, latched in BLOCK
    logic [NUM_REGS-1:0]   w_blk_src;
    logic [NUM_REGS-1:0]   w_blk_rem;
    logic [IDX_W-1:0]      w_blk_reg;

    assign w_blk_src = (r_state == ST_IDLE) ? reg_list : r_list;
    // Clearing the lowest set bit leaves the registers still to be issued
    assign w_blk_rem = w_blk_src & (w_blk_src - NUM_REGS'(1));
    assign w_blk_reg = f_lowest(w_blk_src);

    // State register and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_list   <= '0;
            r_ld     <= 1'b0;
            r_alu    <= '0;
            r_mem_rd <= 1'b0;
            r_mem_wr <= 1'b0;
            r_wb     <= 1'b0;
            r_br     <= 1'b0;
            r_s      <= 1'b0;
            r_uv     <= 1'b0;
            r_reg    <= '0;
            r_idx    <= '0;
            r_last   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_list   <= w_list_nxt;
            r_ld     <= w_ld_nxt;
            r_alu    <= w_alu_nxt;
            r_mem_rd <= w_mem_rd_nxt;
            r_mem_wr <= w_mem_wr_nxt;
            r_wb     <= w_wb_nxt;
            r_br     <= w_br_nxt;
            r_s      <= w_s_nxt;
            r_uv     <= w_uv_nxt;
            r_reg    <= w_reg_nxt;
            r_idx    <= w_idx_nxt;
            r_last   <= w_last_nxt;
            r_busy   <= w_busy_nxt;
        end
    end

    // Next-state and next-output decode; flush beats freeze
    always_comb begin
        w_state_nxt  = r_state;
        w_list_nxt   = r_list;
        w_ld_nxt     = r_ld;
        w_alu_nxt    = '0;
        w_mem_rd_nxt = 1'b0;
        w_mem_wr_nxt = 1'b0;
        w_wb_nxt     = 1'b0;
        w_br_nxt     = 1'b0;
        w_s_nxt      = 1'b0;
        w_uv_nxt     = 1'b0;
        w_reg_nxt    = '0;
        w_idx_nxt    = '0;
        w_last_nxt   = 1'b0;
        w_busy_nxt   = 1'b0;

        if (flush) begin
            w_state_nxt = ST_IDLE;
            w_list_nxt  = '0;
            w_ld_nxt    = 1'b0;
        end else if (freeze) begin
            w_alu_nxt    = r_alu;
            w_mem_rd_nxt = r_mem_rd;
            w_mem_wr_nxt = r_mem_wr;
            w_wb_nxt     = r_wb;
            w_br_nxt     = r_br;
            w_s_nxt      = r_s;
            w_uv_nxt     = r_uv;
            w_reg_nxt    = r_reg;
            w_idx_nxt    = r_idx;
            w_last_nxt   = r_last;
            w_busy_nxt   = r_busy;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (valid_in) begin
                        case (mode)
                            MODE_DP: begin
                                w_uv_nxt  = 1'b1;
                                w_alu_nxt = f_alu(opcode);
                                w_s_nxt   = sIn;
                                w_wb_nxt  = (opcode != OP_CMP) && (opcode != OP_TST);
                            end
                            MODE_LS: begin
                                if (!blk) begin
                                    w_uv_nxt     = 1'b1;
                                    w_alu_nxt    = ALU_ADD;
                                    w_wb_nxt     = sIn;
                                    w_mem_rd_nxt = sIn;
                                    w_mem_wr_nxt = ~sIn;
                                end else if (reg_list != '0) begin
                                    // First micro-op of a block transfer
                                    w_uv_nxt     = 1'b1;
                                    w_alu_nxt    = ALU_ADD;
                                    w_wb_nxt     = sIn;
                                    w_mem_rd_nxt = sIn;
                                    w_mem_wr_nxt = ~sIn;
                                    w_reg_nxt    = w_blk_reg;
                                    w_idx_nxt    = '0;
                                    w_ld_nxt     = sIn;
                                    w_list_nxt   = w_blk_rem;
                                    if (w_blk_rem != '0) begin
                                        w_state_nxt = ST_BLOCK;
                                        w_busy_nxt  = 1'b1;
                                    end else begin
                                        w_last_nxt  = 1'b1;
                                    end
                                end
                                // Empty list: nothing issued
                            end
                            MODE_BR: begin
                                w_uv_nxt = 1'b1;
                                w_br_nxt = 1'b1;
                            end
                            default: begin
                                w_uv_nxt = 1'b1;
                            end
                        endcase
                    end
                end
                ST_BLOCK: begin
                    // Follow-on micro-op; valid_in is ignored while busy
                    w_uv_nxt     = 1'b1;
                    w_alu_nxt    = ALU_ADD;
                    w_wb_nxt     = r_ld;
                    w_mem_rd_nxt = r_ld;
                    w_mem_wr_nxt = ~r_ld;
                    w_reg_nxt    = w_blk_reg;
                    w_idx_nxt    = r_idx + IDX_W'(1);
                    w_list_nxt   = w_blk_rem;
                    if (w_blk_rem == '0) begin
                        w_last_nxt  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_busy_nxt  = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_list_nxt  = '0;
                end
            endcase
        end
    end

    assign aluCmd    = r_alu;
    assign memRead   = r_mem_rd;
    assign memWrite  = r_mem_wr;
    assign wbEn      = r_wb;
    assign branch    = r_br;
    assign sOut      = r_s;
    assign uop_valid = r_uv;
    assign uop_reg   = r_reg;
    assign uop_index = r_idx;
    assign last      = r_last;
    assign busy      = r_busy;

endmodule

// File: tb/tb_block_ctrl_unit.sv
// ----------------------------------------------------------------------------
// tb_block_ctrl_unit
// Directed bench for block_ctrl_unit: decode table, single load/store,
// branch, block transfers, freeze, flush and reset mid-block. Outputs are
// sampled 1 time unit after each rising edge.
// ----------------------------------------------------------------------------
module tb_block_ctrl_unit;

    logic        clk;
    logic        rst;
    logic        valid_in;
    logic [1:0]  mode;
    logic [3:0]  opcode;
    logic        sIn;
    logic        blk;
    logic [15:0] reg_list;
    logic        freeze;
    logic        flush;
    logic [3:0]  aluCmd;
    logic        memRead;
    logic        memWrite;
    logic        wbEn;
    logic        branch;
    logic        sOut;
    logic        uop_valid;
    logic [3:0]  uop_reg;
    logic [3:0]  uop_index;
    logic        last;
    logic        busy;

    int total;
    int bad;

    block_ctrl_unit #(
        .NUM_REGS (16),
        .IDX_W    (4),
        .ALU_CMD_W(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .valid_in (valid_in),
        .mode     (mode),
        .opcode   (opcode),
        .sIn      (sIn),
        .blk      (blk),
        .reg_list (reg_list),
        .freeze   (freeze),
        .flush    (flush),
        .aluCmd   (aluCmd),
        .memRead  (memRead),
        .memWrite (memWrite),
        .wbEn     (wbEn),
        .branch   (branch),
        .sOut     (sOut),
        .uop_valid(uop_valid),
        .uop_reg  (uop_reg),
        .uop_index(uop_index),
        .last     (last),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed outputs packed as {uv, alu, mr, mw, wb, br, s, reg, idx, last, busy}
    function automatic logic [19:0] obs();
        return {uop_valid, aluCmd, memRead, memWrite, wbEn, branch, sOut,
                uop_reg, uop_index, last, busy};
    endfunction

    // Expected-value builder in the same field order
    function automatic logic [19:0] ev(input logic v, input logic [3:0] alu,
                                       input logic mr, input logic mw,
                                       input logic wb, input logic br,
                                       input logic s, input logic [3:0] r,
                                       input logic [3:0] k, input logic l,
                                       input logic b);
        return {v, alu, mr, mw, wb, br, s, r, k, l, b};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] m, input logic [3:0] op,
                         input logic s, input logic bk, input logic [15:0] rl);
        valid_in = v;
        mode     = m;
        opcode   = op;
        sIn      = s;
        blk      = bk;
        reg_list = rl;
    endtask

    task automatic test_reset();
        logic [19:0] e;
        rst    = 1'b1;
        freeze = 1'b0;
        flush  = 1'b0;
        drive(1'b1, 2'b00, 4'b0100, 1'b1, 1'b0, 16'h0000);
        step();
        step();
        e = '0;
        total++;
        if (obs() !== e) begin
            bad++;
            $display("FAIL reset got=%b exp=%b", obs(), e);
        end
        rst = 1'b0;
        drive(1'b0, 2'b00, 4'b0000, 1'b0, 1'b0, 16'h0000);
        step();
        total++;
        if (obs() !== e) begin
            bad++;
            $display("FAIL idle_after_reset got=%b exp=%b", obs(), e);
        end
    endtask

    // Back-to-back data-processing ops over the decode table
    task automatic test_dataproc();
        logic [3:0] ops  [9] = '{4'b0100, 4'b1010, 4'b1000, 4'b1111, 4'b0001,
                                 4'b1100, 4'b0110, 4'b0011, 4'b0101};
        logic       ss   [9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [3:0] alus [9] = '{4'b0010, 4'b0100, 4'b0110, 4'b1001, 4'b1000,
                                 4'b0111, 4'b0101, 4'b0001, 4'b0011};
        logic       wbs  [9] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [19:0] e;
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 2'b00, ops[i], ss[i], 1'b0, 16'h0000);
            step();
            e = ev(1'b1, alus[i], 1'b0, 1'b0, wbs[i], 1'b0, ss[i],
                   4'd0, 4'd0, 1'b0, 1'b0);
            total++;
            if (obs() !== e) begin
                bad++;
                $display("FAIL dp_op%0d got=%b exp=%b", i, obs(), e);
            end
        end
        drive(1'b0, 2'b00, 4'b0100, 1'b1, 1'b0, 16'h0000);
        step();
        e = '0;
        total++;
        if (obs() !== e) begin
            bad++;
            $display("FAIL dp_idle got=%b exp=%b", obs(), e);
        end
    endtask

    // Single LDR/STR, branch and reserved class
    task automatic test_single_ls_branch();
        logic [1:0]  ms [4] = '{2'b01, 2'b01, 2'b10, 2'b11};
        logic        ss [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic [19:0] es [4];
        es[0] = ev(1'b1, 4'b0010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
        es[1] = ev(1'b1, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
        es[2] = ev(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
        es[3] = ev(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, ms[i], 4'b0100, ss[i], 1'b0, 16'h00FF);
            step();
            total++;
            if (obs() !== es[i]) begin
                bad++;
                $display("FAIL ls_br%0d got=%b exp=%b", i, obs(), es[i]);
            end
        end
    endtask

    // LDM {R2,R4,R7} followed without a bubble by MOV
    task automatic test_ldm_back_to_back();
        logic [3:0] regs [3] = '{4'd2, 4'd4, 4'd7};
        logic [19:0] e;
        drive(1'b1, 2'b01, 4'b0000, 1'b1, 1'b1, 16'h0094);
        for (int i = 0; i < 3; i++) begin
            step();
            // MOV waits at decode while busy; it must be ignored until the last uop
            drive(1'b1, 2'b00, 4'b1101, 1'b0, 1'b0, 16'h0000);
            e = ev(1'b1, 4'b0010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0,
                   regs[i], 4'(i), (i == 2), (i != 2));
            total++;
            if (obs() !== e) begin
                bad++;
                $display("FAIL ldm_uop%0d got=%b exp=%b", i, obs(), e);
            end
        end
        step();
        drive(1'b0, 2'b00, 4'b0000, 1'b0, 1'b0, 16'h0000);
        e = ev(1'b1, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
        total++;
        if (obs() !== e) begin
            bad++;
            $display("FAIL ldm_then_mov got=%b exp=%b", obs(), e);
        end
    endtask

    // STM of a single register, then an empty block list
    task automatic test_stm_single_and_empty();
        logic [19:0] e;
        drive(1'b1, 2'b01, 4'b0000, 1'b0, 1'b1, 16'h0001);
        step();
        e = ev(1'b1, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
        total++;
        if (obs() !== e) begin
            bad++;
            $display("FAIL stm_single got=%b exp=%b", obs(), e);
        end
        drive(1'b1, 2'b01, 4'b0000, 1'b1, 1'b1, 16'h0000);
        step();
        e = '0;
        total++;
        if (obs() !== e) begin
            bad++;
            $display("FAIL blk_empty got=%b exp=%b", obs(), e);
        end
        // A single-register block at the top of the list
        drive(1'b1, 2'b01, 4'b0000, 1'b1, 1'b1, 16'h8000);
        step();
        drive(1'b0, 2'b00, 4'b0000, 1'b0, 1'b0, 16'h0000);
        e = ev(1'b1, 4'b0010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd15, 4'd0, 1'b1, 1'b0);
        total++;
        if (obs() !== e) begin
            bad++;
            $display("FAIL ldm_r15 got=%b exp=%b", obs(), e);
        end
    endtask

    // STM R0..R3 with a two-cycle freeze after the first micro-op
    task automatic test_freeze();
        logic [3:0]  regs [6] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3};
        logic [3:0]  idxs [6] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3};
        logic        lsts [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [19:0] e;
        drive(1'b1, 2'b01, 4'b0000, 1'b0, 1'b1, 16'h000F);
        for (int i = 0; i < 6; i++) begin
            step();
            drive(1'b0, 2'b00, 4'b0000, 1'b0, 1'b0, 16'h0000);
            freeze = (i < 2);
            e = ev(1'b1, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                   regs[i], idxs[i], lsts[i], ~lsts[i]);
            total++;
            if (obs() !== e) begin
                bad++;
                $display("FAIL freeze_cyc%0d got=%b exp=%b", i, obs(), e);
            end
        end
        freeze = 1'b0;
        step();
        e = '0;
        total++;
        if (obs() !== e) begin
            bad++;
            $display("FAIL freeze_end got=%b exp=%b", obs(), e);
        end
    endtask

    // LDM R4..R7 flushed (with freeze also high) on the second micro-op
    task automatic test_flush();
        logic [19:0] e;
        drive(1'b1, 2'b01, 4'b0000, 1'b1, 1'b1, 16'h00F0);
        step();
        drive(1'b0, 2'b00, 4'b0000, 1'b0, 1'b0, 16'h0000);
        step();
        e = ev(1'b1, 4'b0010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd5, 4'd1, 1'b0, 1'b1);
        total++;
        if (obs() !== e) begin
            bad++;
            $display("FAIL flush_pre got=%b exp=%b", obs(), e);
        end
        flush  = 1'b1;
        freeze = 1'b1;
        drive(1'b1, 2'b10, 4'b0000, 1'b0, 1'b0, 16'h0000);
        step();
        flush  = 1'b0;
        freeze = 1'b0;
        e = '0;
        total++;
        if (obs() !== e) begin
            bad++;
            $display("FAIL flush_kill got=%b exp=%b", obs(), e);
        end
        step();
        drive(1'b0, 2'b00, 4'b0000, 1'b0, 1'b0, 16'h0000);
        e = ev(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
        total++;
        if (obs() !== e) begin
            bad++;
            $display("FAIL flush_then_b got=%b exp=%b", obs(), e);
        end
        step();
        e = '0;
        total++;
        if (obs() !== e) begin
            bad++;
            $display("FAIL flush_no_resume got=%b exp=%b", obs(), e);
        end
    endtask

    // Reset in the middle of LDM of all registers
    task automatic test_reset_mid_block();
        logic [19:0] e;
        drive(1'b1, 2'b01, 4'b0000, 1'b1, 1'b1, 16'hFFFF);
        step();
        drive(1'b0, 2'b00, 4'b0000, 1'b0, 1'b0, 16'h0000);
        step();
        e = ev(1'b1, 4'b0010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 4'd1, 1'b0, 1'b1);
        total++;
        if (obs() !== e) begin
            bad++;
            $display("FAIL rstmid_pre got=%b exp=%b", obs(), e);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        e = '0;
        total++;
        if (obs() !== e) begin
            bad++;
            $display("FAIL rstmid_kill got=%b exp=%b", obs(), e);
        end
        drive(1'b1, 2'b00, 4'b1111, 1'b0, 1'b0, 16'h0000);
        step();
        drive(1'b0, 2'b00, 4'b0000, 1'b0, 1'b0, 16'h0000);
        e = ev(1'b1, 4'b1001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
        total++;
        if (obs() !== e) begin
            bad++;
            $display("FAIL rstmid_mvn got=%b exp=%b", obs(), e);
        end
        step();
        e = '0;
        total++;
        if (obs() !== e) begin
            bad++;
            $display("FAIL rstmid_no_resume got=%b exp=%b", obs(), e);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_dataproc();
        test_single_ls_branch();
        test_ldm_back_to_back();
        test_stm_single_and_empty();
        test_freeze();
        test_flush();
        test_reset_mid_block();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
